rf_access_arbiter: RTL and testbench
====================================

// Module: rf_access_arbiter
// PURPOSE
//  Shares the single register-file port between two requesters: M0, the UART command controller, and M1, a secondary master such as the config loader or debug path.
//  Sits between both masters and RegFile. Registers each accepted access and issues it as a one-cycle RF_WrEn/RF_RdEn pulse.
//  Returns read data to the owner only. Fair round-robin arbitration; a read timeout guarantees forward progress.
// PARAMETERS
//  DATA_WIDTH  8   RF data width
//  ADDR        4   RF address width
//  RD_TIMEOUT  8   max cycles in WAIT_RD before read is aborted (>=2)
// PORTS
//  CLK              in   1           system clock
//  RST              in   1           async reset, active-low
//  m0_req/m1_req    in   1           access request; held until matching gnt
//  m0_we/m1_we      in   1           1=write, 0=read; stable while req
//  m0_addr/m1_addr  in   ADDR        access address; stable while req
//  m0_wdata/m1_wdata in  DATA_WIDTH  write data; stable while req
//  m0_gnt/m1_gnt    out  1           1-cycle pulse: access issued to RF this cycle
//  m0_rdata/m1_rdata out DATA_WIDTH  read data, valid with rvalid
//  m0_rvalid/m1_rvalid out 1         1-cycle pulse: read completed
//  m0_rerr/m1_rerr  out  1           1-cycle pulse with rvalid: read timed out, rdata=0
//  RF_WrEn          out  1           RF write strobe
//  RF_RdEn          out  1           RF read strobe
//  RF_Address       out  ADDR        RF address
//  RF_WrData        out  DATA_WIDTH  RF write data
//  RF_RdData        in   DATA_WIDTH  RF read data
//  RF_RdData_Valid  in   1           RF read data valid
// BEHAVIOUR
//  Reset (RST low, async): state=IDLE, prio=M0, owner=M0, timeout cnt=0.
//   All outputs 0: gnt, rvalid, rerr, rdata, RF_* strobes/address/data. Any in-flight access is dropped; no rvalid is issued.
//  All outputs are registered. No combinational path from m*_req to any RF_* or gnt output.
//  FSM states: IDLE, ISSUE, WAIT_RD.
//   IDLE: if any req, pick winner, latch owner/we/addr/wdata, go to ISSUE. Else stay.
//    Both requesting: the prio holder wins. One requesting: it wins regardless of prio.
//   ISSUE (exactly 1 cycle): RF_Address/RF_WrData driven from latched values, gnt_owner=1.
//    Write: RF_WrEn=1, then go to IDLE. Read: RF_RdEn=1, cnt=0, then go to WAIT_RD.
//    prio flips to the non-owner on every ISSUE.
//   WAIT_RD: RF_Address holds the latched address. cnt increments each cycle.
//    On RF_RdData_Valid: rdata_owner<=RF_RdData, next cycle rvalid_owner=1, go to IDLE.
//    If cnt reaches RD_TIMEOUT-1 without valid: rdata_owner=0, rvalid_owner=1 and rerr_owner=1 next cycle, go to IDLE.
//  Latency: req seen in IDLE at cycle N -> gnt + RF strobe at N+1.
//   Read with 1-cycle RF latency: RF_RdData_Valid at N+2, rvalid at N+3.
//   Write throughput: 1 access per 2 cycles. Read: 1 per 3 cycles min.
//  rdata of the non-owner holds its last value; only the owner's rvalid/rerr pulse.
//  RF_RdData_Valid outside WAIT_RD: ignored, no rvalid.
//  req dropped after IDLE accept, before gnt: access still issues, gnt still pulses (protocol violation, flagged by assertion).
//  req held after gnt: treated as a new request in the next IDLE sample.
//  IDLE cycle carrying rvalid may accept a new request in the same cycle.
//  Non-owner's req stays pending through ISSUE/WAIT_RD. It gets priority next, so no starvation.
// TESTING
//  1) Reset, then m0 write addr=4'h2 data=8'h5A -> RF_WrEn=1, RF_Address=2, RF_WrData=5A, m0_gnt at N+1. No m1 activity.
//  2) m0 and m1 both read (m0 addr=1, m1 addr=3), RF returns 8'h11/8'h33 with 1-cycle latency.
//     -> m0 served first: m0_rvalid with 11. Then m1: m1_rvalid with 33. m1_rvalid never pulses for m0's read.
//  3) Both masters hold continuous write requests for 20 cycles -> gnts strictly alternate m0,m1,m0,... 5 each.
//  4) m1 read addr=7, RF_RdData_Valid never asserted -> after RD_TIMEOUT cycles: m1_rvalid=1, m1_rerr=1, m1_rdata=0, FSM back in IDLE.
//  5) Assert RST low during WAIT_RD of an m0 read -> all outputs 0 immediately.
//     After release: no m0_rvalid, prio=M0, new m1 request served normally.
//  6) Spurious RF_RdData_Valid pulses in IDLE and ISSUE -> no rvalid on either master, no state change.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one register-file port between two masters.
// Every access is registered and issued as a one-cycle RF strobe; reads time out.
module rf_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR       = 4,
  parameter int RD_TIMEOUT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR-1:0]       m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  output logic                  m0_rerr,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR-1:0]       m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  m1_rerr,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR-1:0]       RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_Valid
);

  localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            gnt_d, rvalid_d, rerr_d;
  logic                  wren_d, rden_d;
  logic [ADDR-1:0]       rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_d, rdata0_d, rdata1_d;
  logic                  win;

  // Both requesting: prio holder wins; otherwise the lone requester wins.
  assign win = (m0_req && m1_req) ? prio_q : m1_req;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    gnt_d      = 2'b00;
    rvalid_d   = 2'b00;
    rerr_d     = 2'b00;
    wren_d     = 1'b0;
    rden_d     = 1'b0;
    rf_addr_d  = RF_Address;
    rf_wdata_d = RF_WrData;
    rdata0_d   = m0_rdata;
    rdata1_d   = m1_rdata;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d    = win;
          we_d       = win ? m1_we : m0_we;
          rf_addr_d  = win ? m1_addr : m0_addr;
          rf_wdata_d = win ? m1_wdata : m0_wdata;
          gnt_d[win] = 1'b1;
          wren_d     = we_d;
          rden_d     = !we_d;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        prio_d  = !owner_q;
        cnt_d   = '0;
        state_d = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (RF_RdData_Valid || cnt_q == CNT_MAX) begin
          if (owner_q) rdata1_d = RF_RdData_Valid ? RF_RdData : '0;
          else         rdata0_d = RF_RdData_Valid ? RF_RdData : '0;
          rvalid_d[owner_q] = 1'b1;
          rerr_d[owner_q]   = !RF_RdData_Valid;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: strobes appear the cycle after the IDLE accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rerr    <= 1'b0;
      m1_rerr    <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      m0_gnt     <= gnt_d[0];
      m1_gnt     <= gnt_d[1];
      m0_rvalid  <= rvalid_d[0];
      m1_rvalid  <= rvalid_d[1];
      m0_rerr    <= rerr_d[0];
      m1_rerr    <= rerr_d[1];
      m0_rdata   <= rdata0_d;
      m1_rdata   <= rdata1_d;
      RF_WrEn    <= wren_d;
      RF_RdEn    <= rden_d;
      RF_Address <= rf_addr_d;
      RF_WrData  <= rf_wdata_d;
    end
  end

`ifndef SYNTHESIS
  // A master must keep req high until its gnt cycle has completed.
  a_req_held_m0 : assert property (@(posedge CLK) disable iff (!RST)
    (state_q == ISSUE && !owner_q) |-> m0_req);
  a_req_held_m1 : assert property (@(posedge CLK) disable iff (!RST)
    (state_q == ISSUE && owner_q) |-> m1_req);
`endif

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter: writes, arbitration order, read
// completion, timeout, mid-read reset and spurious RF valid pulses.
module tb_rf_access_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [3:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr;
  logic [7:0] m0_rdata, m1_rdata;
  logic       RF_WrEn, RF_RdEn, RF_RdData_Valid;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData, RF_RdData;

  int n_cmp = 0;
  int n_err = 0;
  int g0, g1;

  rf_access_arbiter #(.DATA_WIDTH(8), .ADDR(4), .RD_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rerr(m1_rerr),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {28'd0, m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
            m0_rerr, m1_rerr, RF_WrEn, RF_RdEn, RF_Address, RF_WrData};
  endfunction

  task automatic do_reset();
    RST = 1'b0;
    #2;
    chk("reset_outputs_zero", all_out(), 64'd0);
    step();
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    RF_RdData = '0; RF_RdData_Valid = 0;
    step();
    do_reset();

    // 1) m0 write
    m0_req = 1; m0_we = 1; m0_addr = 4'h2; m0_wdata = 8'h5A;
    step();
    chk("t1_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("t1_wren_rden", {RF_WrEn, RF_RdEn}, 2'b10);
    chk("t1_addr", RF_Address, 4'h2);
    chk("t1_wdata", RF_WrData, 8'h5A);
    step();
    m0_req = 0;
    chk("t1_strobe_end", {m1_gnt, m0_gnt, RF_WrEn, RF_RdEn, m0_rvalid, m1_rvalid}, 6'b0);

    // 2) both read, m0 first after reset
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 4'h1;
    m1_req = 1; m1_we = 0; m1_addr = 4'h3;
    step();
    chk("t2_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("t2_m0_rden", {RF_WrEn, RF_RdEn}, 2'b01);
    chk("t2_m0_addr", RF_Address, 4'h1);
    step();
    m0_req = 0; RF_RdData_Valid = 1; RF_RdData = 8'h11;
    chk("t2_wait_quiet", {m1_gnt, m0_gnt, RF_RdEn, m0_rvalid, m1_rvalid}, 5'b0);
    chk("t2_addr_hold", RF_Address, 4'h1);
    step();
    RF_RdData_Valid = 0; RF_RdData = 8'h00;
    chk("t2_m0_rvalid", {m1_rvalid, m0_rvalid, m0_rerr}, 3'b010);
    chk("t2_m0_rdata", m0_rdata, 8'h11);
    step();
    chk("t2_m1_gnt", {m1_gnt, m0_gnt, m0_rvalid}, 3'b100);
    chk("t2_m1_addr", RF_Address, 4'h3);
    step();
    m1_req = 0; RF_RdData_Valid = 1; RF_RdData = 8'h33;
    step();
    RF_RdData_Valid = 0; RF_RdData = 8'h00;
    chk("t2_m1_rvalid", {m1_rvalid, m0_rvalid, m1_rerr}, 3'b100);
    chk("t2_m1_rdata", m1_rdata, 8'h33);
    chk("t2_m0_rdata_hold", m0_rdata, 8'h11);
    step();
    chk("t2_rvalid_pulse", {m1_rvalid, m0_rvalid}, 2'b00);

    // 3) continuous writes from both: strict alternation starting with m0
    m0_req = 1; m0_we = 1; m0_addr = 4'h4; m0_wdata = 8'hA0;
    m1_req = 1; m1_we = 1; m1_addr = 4'h6; m1_wdata = 8'hB1;
    g0 = 0; g1 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      g0 += int'(m0_gnt);
      g1 += int'(m1_gnt);
      chk($sformatf("t3_gnt_k%0d", k), {m1_gnt, m0_gnt},
          (k % 4 == 1) ? 2'b01 : ((k % 4 == 3) ? 2'b10 : 2'b00));
    end
    m0_req = 0; m1_req = 0;
    chk("t3_m0_count", g0, 5);
    chk("t3_m1_count", g1, 5);

    // 4) m1 read with no RF response -> timeout
    step();
    m1_req = 1; m1_we = 0; m1_addr = 4'h7;
    step();
    chk("t4_gnt", {m1_gnt, m0_gnt, RF_RdEn}, 3'b101);
    chk("t4_addr", RF_Address, 4'h7);
    step();
    m1_req = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("t4_waiting_%0d", i), {m1_rvalid, m1_rerr, RF_Address}, {2'b00, 4'h7});
    end
    step();
    chk("t4_timeout_flags", {m1_rvalid, m1_rerr, m0_rvalid, m0_rerr}, 4'b1100);
    chk("t4_timeout_rdata", m1_rdata, 8'h00);
    m0_req = 1; m0_we = 1; m0_addr = 4'hC; m0_wdata = 8'h3C;
    step();
    chk("t4_idle_after", {m1_gnt, m0_gnt, RF_WrEn, m1_rvalid, m1_rerr}, 5'b01100);
    step();
    m0_req = 0;

    // 5) reset during WAIT_RD of an m0 read
    m0_req = 1; m0_we = 0; m0_addr = 4'h5;
    step();
    chk("t5_gnt", {m1_gnt, m0_gnt, RF_RdEn, RF_Address}, {3'b011, 4'h5});
    step();
    m0_req = 0;
    step();
    RST = 1'b0;
    #1;
    chk("t5_async_clear", all_out(), 64'd0);
    step();
    RST = 1'b1;
    RF_RdData_Valid = 1; RF_RdData = 8'h99;
    step();
    RF_RdData_Valid = 0; RF_RdData = 8'h00;
    chk("t5_no_stale_rvalid", {m0_rvalid, m1_rvalid, m0_rdata}, 10'd0);
    m0_req = 1; m0_we = 1; m0_addr = 4'h0; m0_wdata = 8'h01;
    m1_req = 1; m1_we = 0; m1_addr = 4'h9;
    step();
    chk("t5_prio_m0", {m1_gnt, m0_gnt, RF_WrEn}, 3'b011);
    step();
    m0_req = 0;
    step();
    chk("t5_m1_gnt", {m1_gnt, m0_gnt, RF_RdEn, RF_Address}, {3'b101, 4'h9});
    step();
    m1_req = 0; RF_RdData_Valid = 1; RF_RdData = 8'hC3;
    step();
    RF_RdData_Valid = 0; RF_RdData = 8'h00;
    chk("t5_m1_rvalid", {m1_rvalid, m1_rerr, m1_rdata}, {2'b10, 8'hC3});

    // 6) spurious RF_RdData_Valid in IDLE and ISSUE
    step();
    RF_RdData_Valid = 1; RF_RdData = 8'hEE;
    step();
    chk("t6_idle_ignored", {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}, 4'b0);
    m0_req = 1; m0_we = 1; m0_addr = 4'h3; m0_wdata = 8'h77;
    step();
    chk("t6_still_idle", {m1_gnt, m0_gnt, RF_WrEn, m0_rvalid, m1_rvalid}, 5'b01100);
    step();
    m0_req = 0; RF_RdData_Valid = 0; RF_RdData = 8'h00;
    chk("t6_issue_ignored", {m0_rvalid, m1_rvalid, m0_rerr, m1_rerr}, 4'b0);
    chk("t6_rdata_hold", {m0_rdata, m1_rdata}, {8'h00, 8'hC3});
    step();
    chk("t6_quiet", {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, RF_WrEn, RF_RdEn}, 6'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
